ula_mdu: RTL
============

// Module: ula_mdu
// PURPOSE
// - Parametrised, sequential successor of the single-cycle ALU. It adds registered outputs, a valid/ready
//   handshake, and an iterative multiply/divide unit with HI/LO registers for MIPS mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
// - Sits in the EX stage. The pipeline stalls on in_ready=0 while a multi-cycle op runs.
// PARAMETERS
// - WIDTH  32  operand/result width (>=8, power of 2); shift amount = In[$clog2(WIDTH)-1:0]
// PORTS
// - clk          in   1      single clock, all state on rising edge
// - rst_n        in   1      synchronous, active-low reset
// - in_valid     in   1      op/In1/In2 valid this cycle
// - in_ready     out  1      unit can accept; op accepted when in_valid&in_ready
// - OP           in   5      OP[4]=0: base ALU ops (encodings below); OP[4]=1: MDU ops
// - In1, In2     in   WIDTH  operands (In1=rs/shamt, In2=rt)
// - out_valid    out  1      one-cycle pulse, result/flags valid; no backpressure
// - result       out  WIDTH  registered result, held until next out_valid
// - Zero_flag    out  1      (result==0), registered with result
// - div_by_zero  out  1      set with out_valid when div/divu had In2==0
// - illegal_op   out  1      set with out_valid for a reserved/disabled OP
// - hi, lo       out  WIDTH  architectural HI/LO registers
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state=IDLE, in_ready=0 during reset; all outputs, hi, and lo are 0. Reset mid-op aborts it with no out_valid.
// - FSM: IDLE -> MUL|DIV on accept of mult*/div*; MUL|DIV -> IDLE after WIDTH iterations; in_ready=1 only in IDLE.
// - Base ops (OP[4]=0), 1-cycle latency: accepted at edge N, out_valid at N+1, back-to-back allowed:
//   0000 add, 0001 sub, 0011 and, 0100 nor, 0101 or, 0110 xor, 0111 In2<<sh(In1), 1000 In1<<sh(In2),
//   1001 In2>>sh(In1), 1010 In1>>sh(In2), 1100 In2>>>sh(In1), 1101 In1>>>sh(In2) (arith, signed),
//   1110 slt (signed), 1111 sltu; 0010/1011 reserved -> result 0, illegal_op=1.
// - Add/sub wrap modulo 2^WIDTH; no overflow trap.
// - MDU ops (OP[4]=1): 10000 mult, 10001 multu, 10010 div, 10011 divu, 10100 mfhi, 10101 mflo,
//   10110 mthi, 10111 mtlo; 11000-11111 reserved -> result 0, illegal_op=1.
// - mfhi/mflo: 1-cycle, result=hi/lo. mthi/mtlo: 1-cycle, hi/lo<=In1 at the out_valid edge, result=0.
// - mult/multu: radix-2 shift-add on operand magnitudes, one bit per cycle. Accept at N, out_valid at N+WIDTH+1.
//   Signed product negated if signs differ. {hi,lo}<=2*WIDTH product at the out_valid edge; result=lo.
// - div/divu: restoring divider on magnitudes, one quotient bit per cycle, same latency as mult.
//   Signed: quotient sign = sign(In1)^sign(In2); remainder takes sign of In1. lo=quotient, hi=remainder, result=lo.
// - Divide by zero (In2==0): lo=all ones, hi=In1, div_by_zero=1; full latency still taken.
// - Signed MIN/-1: lo=MIN, hi=0 (wraps naturally).
// - hi/lo change only at mult/div completion or mthi/mtlo; they are never partially updated mid-op.
// - in_valid while in_ready=0 is ignored; the source holds it until accepted.
// - Zero_flag, div_by_zero, illegal_op are cleared on every new out_valid unless set by that op.
// CONFIGURATION
// - ULA_MDU_DIV_EN defined: divider built as above.
// - ULA_MDU_DIV_EN undefined: no divider logic. div/divu complete in 1 cycle: result=0, illegal_op=1, hi/lo unchanged,
//   div_by_zero=0. Multiplier unaffected.
// TESTING (WIDTH=32; latency counted from accept edge)
// - add 5+7, then back-to-back sub 5-5 -> out_valid at N+1 result=12 Zero=0, N+2 result=0 Zero=1; in_ready stays 1.
// - sra OP=01100 In1=4 In2=0x80000000 -> 0xF8000000; slt -1<1 -> 1; sltu 0xFFFFFFFF<1 -> 0.
// - mult -3*4 -> in_ready=0 for 32 cycles, out_valid at N+33, hi=0xFFFFFFFF lo=0xFFFFFFF4; then mfhi -> 0xFFFFFFFF.
// - divu 7/2 -> lo=3 hi=1; div -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; div 0x80000000/-1 -> lo=0x80000000 hi=0.
// - div 9/0 -> out_valid at N+33, div_by_zero=1, lo=0xFFFFFFFF hi=9. Without macro: N+1, illegal_op=1, hi/lo unchanged.
// - rst_n=0 at cycle 10 of a mult -> no out_valid, hi=lo=0, in_ready=1 the cycle after rst_n returns to 1; OP=00010 -> illegal_op=1.

Source files
------------

// File: rtl/ula_mdu.sv
// ula_mdu: registered ALU with valid/ready handshake plus an iterative multiply/divide unit owning HI/LO.
// Optional divider: define ULA_MDU_DIV_EN to build it; otherwise div/divu complete in one cycle as illegal ops.
module ula_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             Zero_flag,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
  logic               neg_lo;
`ifdef ULA_MDU_DIV_EN
  logic               neg_hi, dz;
`endif

  logic               accept, start_mul, start_div, single, last;
  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [SW-1:0]      sh1, sh2;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_illegal, wr_hi, wr_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign in_ready  = rst_n && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (OP[4:1] == 4'b1000);
`ifdef ULA_MDU_DIV_EN
  assign start_div = accept && (OP[4:1] == 4'b1001);
`else
  assign start_div = 1'b0;
`endif
  assign single    = accept && !start_mul && !start_div;
  assign last      = (cnt == SW'(WIDTH - 1));

  // mult and div are the signed variants (OP[0]=0); both iterate on magnitudes
  assign signed_op = ~OP[0];
  assign a_neg     = signed_op & In1[WIDTH-1];
  assign b_neg     = signed_op & In2[WIDTH-1];
  assign a_mag     = a_neg ? -In1 : In1;
  assign b_mag     = b_neg ? -In2 : In2;
  assign sh1       = In1[SW-1:0];
  assign sh2       = In2[SW-1:0];

  // One shift-add step: conditionally add multiplicand into the top half, then shift the pair right
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
  assign prod     = {mul_hi_n, mul_lo_n};
  assign prod_fix = neg_lo ? -prod : prod;

`ifdef ULA_MDU_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_hi_n, div_lo_n, quo_fix, rem_fix;

  // Restoring step: shift next dividend bit into the remainder, keep the subtraction if it fits
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand});
  assign div_diff  = div_shift[WIDTH-1:0] - mcand;
  assign div_hi_n  = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};
  assign quo_fix   = dz ? {WIDTH{1'b1}} : (neg_lo ? -div_lo_n : div_lo_n);
  assign rem_fix   = neg_hi ? -div_hi_n : div_hi_n;
`endif

  // Single-cycle ops: base ALU plus HI/LO moves; everything unrecognised reports illegal_op
  always_comb begin
    imm_res     = '0;
    imm_illegal = 1'b0;
    wr_hi       = 1'b0;
    wr_lo       = 1'b0;
    if (!OP[4]) begin
      case (OP[3:0])
        4'b0000: imm_res = In1 + In2;
        4'b0001: imm_res = In1 - In2;
        4'b0011: imm_res = In1 & In2;
        4'b0100: imm_res = ~(In1 | In2);
        4'b0101: imm_res = In1 | In2;
        4'b0110: imm_res = In1 ^ In2;
        4'b0111: imm_res = In2 << sh1;
        4'b1000: imm_res = In1 << sh2;
        4'b1001: imm_res = In2 >> sh1;
        4'b1010: imm_res = In1 >> sh2;
        4'b1100: imm_res = WIDTH'($signed(In2) >>> sh1);
        4'b1101: imm_res = WIDTH'($signed(In1) >>> sh2);
        4'b1110: imm_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
        4'b1111: imm_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
        default: imm_illegal = 1'b1;
      endcase
    end else begin
      case (OP[3:0])
        4'b0100: imm_res = hi;
        4'b0101: imm_res = lo;
        4'b0110: wr_hi = 1'b1;
        4'b0111: wr_lo = 1'b1;
        default: imm_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mul)      state_d = MUL;
        else if (start_div) state_d = DIV;
      end
      MUL, DIV: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // HI/LO are written only on the final iteration, so an abort by reset leaves no partial update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      mcand       <= '0;
      neg_lo      <= 1'b0;
`ifdef ULA_MDU_DIV_EN
      neg_hi      <= 1'b0;
      dz          <= 1'b0;
`endif
      out_valid   <= 1'b0;
      result      <= '0;
      Zero_flag   <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;

      if (single) begin
        out_valid   <= 1'b1;
        result      <= imm_res;
        Zero_flag   <= (imm_res == '0);
        div_by_zero <= 1'b0;
        illegal_op  <= imm_illegal;
        if (wr_hi) hi <= In1;
        if (wr_lo) lo <= In1;
      end

      if (start_mul) begin
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= b_mag;
        mcand  <= a_mag;
        neg_lo <= a_neg ^ b_neg;
      end

`ifdef ULA_MDU_DIV_EN
      if (start_div) begin
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= a_mag;
        mcand  <= b_mag;
        neg_lo <= a_neg ^ b_neg;
        neg_hi <= a_neg;
        dz     <= (In2 == '0);
      end
`endif

      case (state_q)
        MUL: begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi          <= prod_fix[2*WIDTH-1:WIDTH];
            lo          <= prod_fix[WIDTH-1:0];
            result      <= prod_fix[WIDTH-1:0];
            Zero_flag   <= (prod_fix[WIDTH-1:0] == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
`ifdef ULA_MDU_DIV_EN
        DIV: begin
          acc_hi <= div_hi_n;
          acc_lo <= div_lo_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            hi          <= rem_fix;
            lo          <= quo_fix;
            result      <= quo_fix;
            Zero_flag   <= (quo_fix == '0);
            div_by_zero <= dz;
            illegal_op  <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
